// File: rtl/axi4_lite_sram.sv
// axi4_lite_sram: AXI4-Lite slave over a word-addressed SRAM with independent read/write FSMs
// and configurable response latency; out-of-range accesses answer SLVERR.
module axi4_lite_sram #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 4,
    parameter int RESP_WIDTH = 2,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE = 32'h8000_0000,
    parameter int MEM_DEPTH = 1024,
    parameter int RD_DELAY = 1,
    parameter int WR_DELAY = 1
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  pAXI4_ar_valid,
    output logic                  pAXI4_ar_ready,
    input  logic [ADDR_WIDTH-1:0] pAXI4_ar_bits_addr,
    output logic                  pAXI4_r_valid,
    input  logic                  pAXI4_r_ready,
    output logic [DATA_WIDTH-1:0] pAXI4_r_bits_data,
    output logic [RESP_WIDTH-1:0] pAXI4_r_bits_resp,
    input  logic                  pAXI4_aw_valid,
    output logic                  pAXI4_aw_ready,
    input  logic [ADDR_WIDTH-1:0] pAXI4_aw_bits_addr,
    input  logic                  pAXI4_w_valid,
    output logic                  pAXI4_w_ready,
    input  logic [DATA_WIDTH-1:0] pAXI4_w_bits_data,
    input  logic [MASK_WIDTH-1:0] pAXI4_w_bits_strb,
    output logic                  pAXI4_b_valid,
    input  logic                  pAXI4_b_ready,
    output logic [RESP_WIDTH-1:0] pAXI4_b_bits_resp
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(4 * MEM_DEPTH);
    localparam logic [RESP_WIDTH-1:0] OKAY = '0;
    localparam logic [RESP_WIDTH-1:0] SLVERR = RESP_WIDTH'(2);

    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_WAIT, WR_RESP} wr_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    rd_state_t rd_state, rd_next;
    wr_state_t wr_state, wr_next;
    logic [3:0] rd_cnt, wr_cnt;
    logic [ADDR_WIDTH-1:0] rd_addr, wr_addr, rd_off, wr_off;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [MASK_WIDTH-1:0] wr_strb;
    logic aw_held, w_held, ar_hs, aw_hs, w_hs, aw_have, w_have;
    logic rd_ok, wr_ok, rd_capture, wr_commit;

    assign ar_hs = pAXI4_ar_valid & pAXI4_ar_ready;
    assign aw_hs = pAXI4_aw_valid & pAXI4_aw_ready;
    assign w_hs = pAXI4_w_valid & pAXI4_w_ready;
    assign aw_have = aw_held | aw_hs;
    assign w_have = w_held | w_hs;
    assign rd_off = rd_addr - MEM_BASE;
    assign wr_off = wr_addr - MEM_BASE;
    assign rd_ok = rd_addr >= MEM_BASE && rd_off < MEM_BYTES;
    assign wr_ok = wr_addr >= MEM_BASE && wr_off < MEM_BYTES;
    assign rd_capture = rd_state == RD_WAIT && rd_cnt == 4'd1;
    assign wr_commit = wr_state == WR_WAIT && wr_cnt == 4'd1;

    always_comb begin
        rd_next = rd_state;
        rd_next = rd_state == RD_IDLE ? (ar_hs ? RD_WAIT : RD_IDLE) :
                  rd_state == RD_WAIT ? (rd_capture ? RD_RESP : RD_WAIT) :
                  (pAXI4_r_ready ? RD_IDLE : RD_RESP);
    end

    always_comb begin
        wr_next = wr_state;
        wr_next = wr_state == WR_IDLE ? (aw_have && w_have ? WR_WAIT : WR_IDLE) :
                  wr_state == WR_WAIT ? (wr_commit ? WR_RESP : WR_WAIT) :
                  (pAXI4_b_ready ? WR_IDLE : WR_RESP);
    end

    // Outputs are registered from the next state so nothing combinational reaches a port.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            rd_state <= RD_IDLE;
            rd_cnt <= '0;
            pAXI4_ar_ready <= 1'b0;
            pAXI4_r_valid <= 1'b0;
            pAXI4_r_bits_data <= '0;
            pAXI4_r_bits_resp <= '0;
        end else begin
            rd_state <= rd_next;
            pAXI4_ar_ready <= rd_next == RD_IDLE;
            pAXI4_r_valid <= rd_next == RD_RESP;
            if (ar_hs) begin
                rd_addr <= pAXI4_ar_bits_addr;
                rd_cnt <= 4'(RD_DELAY);
            end else if (rd_state == RD_WAIT) begin
                rd_cnt <= rd_cnt - 4'd1;
            end
            if (rd_capture) begin
                pAXI4_r_bits_data <= rd_ok ? mem[rd_off[IDX_W+1:2]] : '0;
                pAXI4_r_bits_resp <= rd_ok ? OKAY : SLVERR;
            end
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            wr_state <= WR_IDLE;
            wr_cnt <= '0;
            aw_held <= 1'b0;
            w_held <= 1'b0;
            pAXI4_aw_ready <= 1'b0;
            pAXI4_w_ready <= 1'b0;
            pAXI4_b_valid <= 1'b0;
            pAXI4_b_bits_resp <= '0;
        end else begin
            wr_state <= wr_next;
            aw_held <= wr_next == WR_IDLE && aw_have;
            w_held <= wr_next == WR_IDLE && w_have;
            pAXI4_aw_ready <= wr_next == WR_IDLE && !aw_have;
            pAXI4_w_ready <= wr_next == WR_IDLE && !w_have;
            pAXI4_b_valid <= wr_next == WR_RESP;
            if (aw_hs) wr_addr <= pAXI4_aw_bits_addr;
            if (w_hs) begin
                wr_data <= pAXI4_w_bits_data;
                wr_strb <= pAXI4_w_bits_strb;
            end
            if (wr_state == WR_IDLE && wr_next == WR_WAIT) wr_cnt <= 4'(WR_DELAY);
            else if (wr_state == WR_WAIT) wr_cnt <= wr_cnt - 4'd1;
            if (wr_commit) pAXI4_b_bits_resp <= wr_ok ? OKAY : SLVERR;
        end
    end

    // Memory is never reset; a read capturing in the commit cycle sees the old word.
    always_ff @(posedge iClock) begin
        if (!iReset && wr_commit && wr_ok) begin
            for (int i = 0; i < MASK_WIDTH; i++)
                if (wr_strb[i]) mem[wr_off[IDX_W+1:2]][8*i +: 8] <= wr_data[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_axi4_lite_sram.sv
// tb_axi4_lite_sram: directed AXI4-Lite transactions against the SRAM model with
// RD_DELAY=WR_DELAY=3, checking latency, data, responses and reset behaviour.
module tb_axi4_lite_sram;
    logic iClock = 1'b0, iReset = 1'b1;
    logic ar_valid = 1'b0, ar_ready, r_valid, r_ready = 1'b0;
    logic aw_valid = 1'b0, aw_ready, w_valid = 1'b0, w_ready, b_valid, b_ready = 1'b0;
    logic [31:0] ar_addr = '0, aw_addr = '0, w_data = '0, r_data;
    logic [3:0] w_strb = '0;
    logic [1:0] r_resp, b_resp;
    int checks = 0, errors = 0;

    axi4_lite_sram #(.RD_DELAY(3), .WR_DELAY(3)) dut (
        .iClock(iClock), .iReset(iReset),
        .pAXI4_ar_valid(ar_valid), .pAXI4_ar_ready(ar_ready), .pAXI4_ar_bits_addr(ar_addr),
        .pAXI4_r_valid(r_valid), .pAXI4_r_ready(r_ready),
        .pAXI4_r_bits_data(r_data), .pAXI4_r_bits_resp(r_resp),
        .pAXI4_aw_valid(aw_valid), .pAXI4_aw_ready(aw_ready), .pAXI4_aw_bits_addr(aw_addr),
        .pAXI4_w_valid(w_valid), .pAXI4_w_ready(w_ready),
        .pAXI4_w_bits_data(w_data), .pAXI4_w_bits_strb(w_strb),
        .pAXI4_b_valid(b_valid), .pAXI4_b_ready(b_ready), .pAXI4_b_bits_resp(b_resp)
    );

    always #5 iClock = ~iClock;

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int w_lead, input logic [1:0] resp);
        int n = 0;
        aw_addr = a;
        w_data = d;
        w_strb = s;
        w_valid = 1'b1;
        if (w_lead > 0) begin
            tick();
            w_valid = 1'b0;
            for (int i = 0; i < w_lead - 1; i++) begin
                check({tag, "_wrdy_low"}, {31'b0, w_ready}, 32'd0);
                tick();
            end
            check({tag, "_wrdy_low"}, {31'b0, w_ready}, 32'd0);
        end
        aw_valid = 1'b1;
        tick();
        aw_valid = 1'b0;
        w_valid = 1'b0;
        check({tag, "_rdy_drop"}, {30'b0, aw_ready, w_ready}, 32'd0);
        b_ready = 1'b1;
        do begin
            tick();
            n++;
        end while (!b_valid && n < 20);
        check({tag, "_b_lat"}, n, 32'd3);
        check({tag, "_b_resp"}, {30'b0, b_resp}, {30'b0, resp});
        tick();
        check({tag, "_b_done"}, {29'b0, b_valid, aw_ready, w_ready}, 32'b011);
        b_ready = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] resp, input int hold);
        int n = 0;
        ar_addr = a;
        ar_valid = 1'b1;
        r_ready = hold == 0;
        tick();
        ar_valid = 1'b0;
        check({tag, "_ar_drop"}, {31'b0, ar_ready}, 32'd0);
        do begin
            tick();
            n++;
        end while (!r_valid && n < 20);
        check({tag, "_r_lat"}, n, 32'd3);
        check({tag, "_r_data"}, r_data, d);
        check({tag, "_r_resp"}, {30'b0, r_resp}, {30'b0, resp});
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_ctl"}, {30'b0, r_valid, ar_ready}, 32'b10);
            check({tag, "_hold_data"}, r_data, d);
            check({tag, "_hold_resp"}, {30'b0, r_resp}, {30'b0, resp});
        end
        r_ready = 1'b1;
        tick();
        check({tag, "_r_done"}, {30'b0, r_valid, ar_ready}, 32'b01);
        r_ready = 1'b0;
    endtask

    initial begin
        ar_valid = 1'b1;
        aw_valid = 1'b1;
        w_valid = 1'b1;
        r_ready = 1'b1;
        b_ready = 1'b1;
        ar_addr = 32'h8000_0000;
        aw_addr = 32'h8000_0000;
        w_data = 32'hFFFF_FFFF;
        w_strb = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ctl", {27'b0, ar_ready, aw_ready, w_ready, r_valid, b_valid}, 32'd0);
        end
        check("rst_r_data", r_data, 32'd0);
        check("rst_resp", {28'b0, r_resp, b_resp}, 32'd0);
        iReset = 1'b0;
        {ar_valid, aw_valid, w_valid, r_ready, b_ready} = '0;
        tick();
        check("rel_ready", {29'b0, ar_ready, aw_ready, w_ready}, 32'b111);
        check("rel_valid", {30'b0, r_valid, b_valid}, 32'd0);

        do_write("wr_same", 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 0, 2'b00);
        do_read("rd_beef", 32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 0);
        do_write("wr_wfirst", 32'h8000_0012, 32'h0000_00AA, 4'b0001, 3, 2'b00);
        do_read("rd_hold", 32'h8000_0010, 32'hDEAD_BEAA, 2'b00, 5);
        do_read("rd_zero", 32'h0000_0000, 32'h0000_0000, 2'b10, 0);
        do_write("wr_oor", 32'h9000_0000, 32'h1234_5678, 4'b1111, 0, 2'b10);
        do_read("rd_after_oor", 32'h8000_0010, 32'hDEAD_BEAA, 2'b00, 0);
        do_read("rd_oor_word", 32'h9000_0000, 32'h0000_0000, 2'b10, 0);
        do_write("wr_last", 32'h8000_0FFC, 32'h1122_3344, 4'b1111, 0, 2'b00);
        do_write("wr_last_part", 32'h8000_0FFC, 32'hAABB_CCDD, 4'b1010, 0, 2'b00);
        do_read("rd_last", 32'h8000_0FFC, 32'hAA22_CC44, 2'b00, 0);
        do_read("rd_past_end", 32'h8000_1000, 32'h0000_0000, 2'b10, 0);
        do_read("rd_below_base", 32'h7FFF_FFFC, 32'h0000_0000, 2'b10, 0);

        ar_addr = 32'h8000_0010;
        ar_valid = 1'b1;
        tick();
        ar_valid = 1'b0;
        tick();
        iReset = 1'b1;
        tick();
        check("midrst_rv", {31'b0, r_valid}, 32'd0);
        iReset = 1'b0;
        tick();
        check("midrst_rel", {29'b0, ar_ready, aw_ready, w_ready}, 32'b111);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("midrst_no_rv", {31'b0, r_valid}, 32'd0);
        end
        do_read("rd_after_rst", 32'h8000_0010, 32'hDEAD_BEAA, 2'b00, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
